// File: rtl/edc_pkg.sv
// Shared definitions for the (39,32) Hamming SECDED encoder and checker.
//   CHK_W      : check-bit width (7 = six Hamming bits + overall parity)
//   DATA_POS   : codeword position of each data bit (non-powers-of-two from 3)
//   CHK_MASK   : per Hamming bit, the data bits whose position has that bit set
//   err_class_e: decode outcome {CLEAN, SEC, DED}
//   edc_encode : check-bit generator sharing the same tables
package edc_pkg;

  localparam int CHK_W   = 7;
  localparam int SYN_W   = 6;
  localparam int DATA_W  = 32;
  localparam int MAX_POS = 38;

  typedef enum logic [1:0] {
    CLEAN = 2'd0,
    SEC   = 2'd1,
    DED   = 2'd2
  } err_class_e;

  // Entry [i] is the codeword position of data bit i.
  localparam logic [DATA_W-1:0][SYN_W-1:0] DATA_POS = {
    6'd38, 6'd37, 6'd36, 6'd35, 6'd34, 6'd33,
    6'd31, 6'd30, 6'd29, 6'd28, 6'd27, 6'd26, 6'd25, 6'd24,
    6'd23, 6'd22, 6'd21, 6'd20, 6'd19, 6'd18, 6'd17,
    6'd15, 6'd14, 6'd13, 6'd12, 6'd11, 6'd10, 6'd9,
    6'd7,  6'd6,  6'd5,  6'd3
  };

  function automatic logic [SYN_W-1:0][DATA_W-1:0] build_chk_masks();
    logic [SYN_W-1:0][DATA_W-1:0] m;
    m = '0;
    for (int k = 0; k < SYN_W; k++) begin
      for (int i = 0; i < DATA_W; i++) begin
        m[k][i] = DATA_POS[i][k];
      end
    end
    return m;
  endfunction

  localparam logic [SYN_W-1:0][DATA_W-1:0] CHK_MASK = build_chk_masks();

  function automatic logic is_pow2(input logic [SYN_W-1:0] v);
    return (v != '0) && ((v & (v - 6'd1)) == '0);
  endfunction

  // Check bits for a data word; bit 6 makes the whole 39-bit word even parity.
  function automatic logic [CHK_W-1:0] edc_encode(input logic [DATA_W-1:0] dat);
    logic [CHK_W-1:0] c;
    c = '0;
    for (int k = 0; k < SYN_W; k++) begin
      c[k] = ^(dat & CHK_MASK[k]);
    end
    c[CHK_W-1] = (^dat) ^ (^c[SYN_W-1:0]);
    return c;
  endfunction

endpackage

// File: rtl/edc_checker_if.sv
// Stream interface of the EDC checker.
//   slave : checker side (takes i_valid/i_dat/i_chk/i_ready, drives the rest)
//   master: producer/consumer side, the mirror image
// Port names keep the checker's i_/o_ orientation on both modports.
interface edc_checker_if #(
  parameter int WB_DWIDTH = 32
);
  import edc_pkg::*;

  logic                 i_valid;
  logic                 o_ready;
  logic [WB_DWIDTH-1:0] i_dat;
  logic [CHK_W-1:0]     i_chk;
  logic                 o_valid;
  logic                 i_ready;
  logic [WB_DWIDTH-1:0] o_dat;
  logic                 o_sec;
  logic                 o_ded;
  logic [CHK_W-1:0]     o_syndrome;

  modport slave (
    input  i_valid, i_dat, i_chk, i_ready,
    output o_ready, o_valid, o_dat, o_sec, o_ded, o_syndrome
  );

  modport master (
    output i_valid, i_dat, i_chk, i_ready,
    input  o_ready, o_valid, o_dat, o_sec, o_ded, o_syndrome
  );

endinterface

// File: rtl/edc_syndrome.sv
// Combinational SECDED syndrome, classification and single-bit correction.
//   dat, chk  : received data word and check bits
//   dat_cor   : corrected data (unchanged for CLEAN, check-bit SEC and DED)
//   syndrome  : {overall parity, s[5:0]}
//   err_class : CLEAN / SEC / DED
module edc_syndrome
  import edc_pkg::*;
(
  input  logic [DATA_W-1:0] dat,
  input  logic [CHK_W-1:0]  chk,
  output logic [DATA_W-1:0] dat_cor,
  output logic [CHK_W-1:0]  syndrome,
  output err_class_e        err_class
);

  logic [SYN_W-1:0]  s;
  logic              p;
  logic [DATA_W-1:0] flip;

  always_comb begin
    s    = '0;
    flip = '0;
    for (int k = 0; k < SYN_W; k++) begin
      s[k] = (^(dat & CHK_MASK[k])) ^ chk[k];
    end
    p = (^dat) ^ (^chk);
    // One-hot of the data bit whose position equals the syndrome.
    for (int i = 0; i < DATA_W; i++) begin
      flip[i] = (s == DATA_POS[i]);
    end

    dat_cor   = dat;
    err_class = CLEAN;
    if (!p) begin
      // Even parity with a nonzero syndrome means two bits flipped.
      err_class = (s == '0) ? CLEAN : DED;
    end else if ((s == '0) || is_pow2(s)) begin
      // Overall parity bit or a Hamming check bit flipped; data is intact.
      err_class = SEC;
    end else if (s > 6'(MAX_POS)) begin
      err_class = DED;
    end else begin
      err_class = SEC;
      dat_cor   = dat ^ flip;
    end
    syndrome = {p, s};
  end

endmodule

// File: rtl/edc_checker.sv
// EDC checker: SECDED (39,32) decode with a single valid/ready output stage.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   bus (slave)    : i_valid/o_ready/i_dat/i_chk in, o_valid/i_ready/o_dat/
//                    o_sec/o_ded/o_syndrome out; latency 1, full throughput
//   i_clr          : synchronous clear of counters and sticky flag
//   o_sec_cnt, o_ded_cnt, o_err_sticky : saturating error statistics
// Optional feature: define EDC_CHECKER_COUNTERS_EN to build the counters and
// sticky flag; otherwise they read 0 and i_clr is ignored.
module edc_checker
  import edc_pkg::*;
#(
  parameter int WB_DWIDTH = 32,
  parameter int WB_SWIDTH = 4,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  edc_checker_if.slave         bus,
  input  logic                 i_clr,
  output logic [CNT_WIDTH-1:0] o_sec_cnt,
  output logic [CNT_WIDTH-1:0] o_ded_cnt,
  output logic                 o_err_sticky
);

  if (WB_DWIDTH != 32) begin : g_bad_width
    $error("edc_checker: WB_DWIDTH must be 32");
  end

  // Byte selects travel with the bus but play no part in decoding.
  localparam int unused_swidth = WB_SWIDTH;

  logic              accept;
  logic [DATA_W-1:0] dat_p0;
  logic [CHK_W-1:0]  syn_p0;
  err_class_e        cls_p0;

  logic              vld_p1;
  logic [DATA_W-1:0] dat_p1;
  logic              sec_p1;
  logic              ded_p1;
  logic [CHK_W-1:0]  syn_p1;

  edc_syndrome u_syndrome (
    .dat       (bus.i_dat),
    .chk       (bus.i_chk),
    .dat_cor   (dat_p0),
    .syndrome  (syn_p0),
    .err_class (cls_p0)
  );

  assign bus.o_ready = !vld_p1 || bus.i_ready;
  assign accept      = bus.i_valid && bus.o_ready;

  // p0 -> p1: output register, loads only on acceptance.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vld_p1 <= 1'b0;
      dat_p1 <= '0;
      sec_p1 <= 1'b0;
      ded_p1 <= 1'b0;
      syn_p1 <= '0;
    end else begin
      if (accept) begin
        vld_p1 <= 1'b1;
        dat_p1 <= dat_p0;
        sec_p1 <= (cls_p0 == SEC);
        ded_p1 <= (cls_p0 == DED);
        syn_p1 <= syn_p0;
      end else if (bus.i_ready) begin
        // Not accepting while ready is high implies no new word: drain.
        vld_p1 <= 1'b0;
      end
    end
  end

  assign bus.o_valid    = vld_p1;
  assign bus.o_dat      = dat_p1;
  assign bus.o_sec      = sec_p1;
  assign bus.o_ded      = ded_p1;
  assign bus.o_syndrome = syn_p1;

`ifdef EDC_CHECKER_COUNTERS_EN
  logic [CNT_WIDTH-1:0] sec_cnt;
  logic [CNT_WIDTH-1:0] ded_cnt;
  logic                 sticky;

  // Clear wins over a same-cycle event; counters saturate at all-ones.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sec_cnt <= '0;
      ded_cnt <= '0;
      sticky  <= 1'b0;
    end else if (i_clr) begin
      sec_cnt <= '0;
      ded_cnt <= '0;
      sticky  <= 1'b0;
    end else if (accept) begin
      if ((cls_p0 == SEC) && (sec_cnt != '1)) begin
        sec_cnt <= sec_cnt + CNT_WIDTH'(1);
      end
      if ((cls_p0 == DED) && (ded_cnt != '1)) begin
        ded_cnt <= ded_cnt + CNT_WIDTH'(1);
      end
      if (cls_p0 != CLEAN) begin
        sticky <= 1'b1;
      end
    end
  end

  assign o_sec_cnt    = sec_cnt;
  assign o_ded_cnt    = ded_cnt;
  assign o_err_sticky = sticky;
`else
  logic unused_clr;
  assign unused_clr   = i_clr;
  assign o_sec_cnt    = '0;
  assign o_ded_cnt    = '0;
  assign o_err_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_edc_checker.sv
// Scoreboard bench for edc_checker: a positional Hamming model predicts each
// accepted word, a monitor pops and compares whenever a word leaves the DUT.
module tb_edc_checker;

  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;
`ifdef EDC_CHECKER_COUNTERS_EN
  localparam int SAT_EXP = CMAX;
`else
  localparam int SAT_EXP = 0;
`endif

  typedef struct packed {
    logic [31:0] dat;
    logic        sec;
    logic        ded;
    logic [6:0]  syn;
  } exp_t;

  logic          i_clk   = 1'b0;
  logic          i_rst_n = 1'b1;
  logic          i_clr   = 1'b0;
  logic [CW-1:0] o_sec_cnt;
  logic [CW-1:0] o_ded_cnt;
  logic          o_err_sticky;

  edc_checker_if #(.WB_DWIDTH(32)) bus ();

  edc_checker #(.WB_DWIDTH(32), .WB_SWIDTH(4), .CNT_WIDTH(CW)) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .bus          (bus),
    .i_clr        (i_clr),
    .o_sec_cnt    (o_sec_cnt),
    .o_ded_cnt    (o_ded_cnt),
    .o_err_sticky (o_err_sticky)
  );

  always #5 i_clk = ~i_clk;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   m_sec = 0;
  int   m_ded = 0;
  bit   m_sticky = 1'b0;
  bit   acc_seen = 1'b0;
  bit   hold_v = 1'b0;
  logic [40:0] held;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

  // Codeword laid out by position: [0] overall parity, check bit k at 2^k,
  // data bits in ascending order at the remaining positions 3..38.
  function automatic logic [38:0] to_cw(input logic [31:0] d, input logic [6:0] c);
    logic [38:0] cw;
    int di;
    cw = '0;
    di = 0;
    cw[0] = c[6];
    for (int p = 1; p <= 38; p++) begin
      if (pow2(p)) begin
        for (int k = 0; k < 6; k++) if (p == (1 << k)) cw[p] = c[k];
      end else begin
        cw[p] = d[di];
        di++;
      end
    end
    return cw;
  endfunction

  function automatic logic [31:0] from_cw(input logic [38:0] cw);
    logic [31:0] d;
    int di;
    d = '0;
    di = 0;
    for (int p = 1; p <= 38; p++) begin
      if (!pow2(p)) begin
        d[di] = cw[p];
        di++;
      end
    end
    return d;
  endfunction

  function automatic logic [6:0] ref_encode(input logic [31:0] d);
    logic [38:0] cw;
    int s;
    logic [6:0] c;
    cw = to_cw(d, 7'h00);
    s = 0;
    for (int p = 1; p <= 38; p++) if (cw[p]) s = s ^ p;
    c[5:0] = s[5:0];
    c[6] = (^d) ^ (^c[5:0]);
    return c;
  endfunction

  // cls: 0 clean, 1 SEC, 2 DED
  task automatic ref_check(input logic [31:0] d, input logic [6:0] c,
                           output exp_t e, output int cls);
    logic [38:0] cw;
    int s;
    logic par;
    cw = to_cw(d, c);
    s = 0;
    for (int p = 1; p <= 38; p++) if (cw[p]) s = s ^ p;
    par = ^cw;
    e.syn = {par, s[5:0]};
    e.dat = d;
    e.sec = 1'b0;
    e.ded = 1'b0;
    cls = 0;
    if (!par) begin
      if (s != 0) begin e.ded = 1'b1; cls = 2; end
    end else if (s == 0 || pow2(s)) begin
      e.sec = 1'b1; cls = 1;
    end else if (s > 38) begin
      e.ded = 1'b1; cls = 2;
    end else begin
      e.sec = 1'b1; cls = 1;
      cw[s] = ~cw[s];
      e.dat = from_cw(cw);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] d, input logic sec, input logic ded,
                              input logic [6:0] syn);
    exp_t e;
    e.dat = d; e.sec = sec; e.ded = ded; e.syn = syn;
    return e;
  endfunction

  task automatic drive(input bit v, input logic [31:0] d, input logic [6:0] c,
                       input bit rdy, input bit clr, input bit dir, input exp_t dex,
                       output bit acc);
    exp_t e;
    int cls;
    int ns, nd;
    bit nst;
    @(negedge i_clk);
    bus.i_valid = v;
    bus.i_dat   = d;
    bus.i_chk   = c;
    bus.i_ready = rdy;
    i_clr       = clr;
    #1;
    acc = v && bus.o_ready;
    ref_check(d, c, e, cls);
    if (acc) sb.push_back(dir ? dex : e);
    ns = m_sec; nd = m_ded; nst = m_sticky;
`ifdef EDC_CHECKER_COUNTERS_EN
    if (clr) begin
      ns = 0; nd = 0; nst = 1'b0;
    end else if (acc) begin
      if (cls == 1 && ns < CMAX) ns++;
      if (cls == 2 && nd < CMAX) nd++;
      if (cls != 0) nst = 1'b1;
    end
`endif
    @(posedge i_clk);
    #1;
    m_sec = ns; m_ded = nd; m_sticky = nst; acc_seen = acc;
  endtask

  // Monitor: samples mid-low-phase, after the driver has settled the inputs.
  always @(negedge i_clk) begin
    exp_t e;
    #2;
    if (!i_rst_n) begin
      hold_v = 1'b0;
    end else begin
      chk("o_ready", 64'(bus.o_ready), 64'(!bus.o_valid || bus.i_ready));
      if (acc_seen) chk("latency_valid", 64'(bus.o_valid), 64'd1);
      if (hold_v && bus.o_valid)
        chk("stall_hold", 64'({bus.o_dat, bus.o_sec, bus.o_ded, bus.o_syndrome}), 64'(held));
      hold_v = bus.o_valid && !bus.i_ready;
      held   = {bus.o_dat, bus.o_sec, bus.o_ded, bus.o_syndrome};
      if (bus.o_valid && bus.i_ready) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL extra_word: got dat %0h with nothing expected", bus.o_dat);
        end else begin
          e = sb.pop_front();
          chk("o_dat", 64'(bus.o_dat), 64'(e.dat));
          chk("o_sec", 64'(bus.o_sec), 64'(e.sec));
          chk("o_ded", 64'(bus.o_ded), 64'(e.ded));
          chk("o_syndrome", 64'(bus.o_syndrome), 64'(e.syn));
        end
      end
      chk("o_sec_cnt", 64'(o_sec_cnt), 64'(m_sec));
      chk("o_ded_cnt", 64'(o_ded_cnt), 64'(m_ded));
      chk("o_err_sticky", 64'(o_err_sticky), 64'(m_sticky));
    end
  end

  initial begin
    logic [31:0] d, w[4];
    logic [6:0]  c;
    logic [38:0] cwv;
    bit          acc, v, rdy, clr;
    int          idx, mode, b1, b2;
    exp_t        nx;

    nx = '0;
    bus.i_valid = 1'b0;
    bus.i_dat   = '0;
    bus.i_chk   = '0;
    bus.i_ready = 1'b0;
    #1 i_rst_n = 1'b0;
    #1;
    chk("rst_o_valid", 64'(bus.o_valid), 64'd0);
    chk("rst_o_dat", 64'(bus.o_dat), 64'd0);
    chk("rst_flags", 64'({bus.o_sec, bus.o_ded}), 64'd0);
    chk("rst_o_syndrome", 64'(bus.o_syndrome), 64'd0);
    chk("rst_counts", 64'({o_sec_cnt, o_ded_cnt, o_err_sticky}), 64'd0);
    chk("rst_o_ready", 64'(bus.o_ready), 64'd1);
    #26 i_rst_n = 1'b1;

    // Known-answer words.
    drive(1, 32'h0000_0000, 7'h00, 1, 0, 1, mk(32'h0000_0000, 0, 0, 7'h00), acc);
    drive(1, 32'h0000_0000, 7'h43, 1, 0, 1, mk(32'h0000_0001, 1, 0, 7'h43), acc);
    drive(1, 32'h0000_0003, 7'h00, 1, 0, 1, mk(32'h0000_0003, 0, 1, 7'h06), acc);
    drive(0, 32'h0, 7'h0, 1, 0, 0, nx, acc);

    // Four words against a three-cycle downstream stall.
    for (int k = 0; k < 4; k++) w[k] = $urandom;
    w[2][5] = ~w[2][5];
    idx = 0;
    for (int t = 0; t < 14; t++) begin
      rdy = !(t >= 1 && t <= 3);
      if (idx < 4) begin
        c = ref_encode(w[idx]);
        if (idx == 2) begin
          d = w[idx];
          d[5] = ~d[5];
          drive(1, w[idx], ref_encode(d), rdy, 0, 0, nx, acc);
        end else begin
          drive(1, w[idx], c, rdy, 0, 0, nx, acc);
        end
        if (acc) idx++;
      end else begin
        drive(0, 32'h0, 7'h0, rdy, 0, 0, nx, acc);
      end
    end
    chk("stall_all_issued", 64'(idx), 64'd4);

    // Saturate the SEC counter, then clear alongside one more SEC word.
    for (int k = 0; k < 17; k++) begin
      d = $urandom;
      c = ref_encode(d);
      d[$urandom_range(0, 31)] ^= 1'b1;
      drive(1, d, c, 1, 0, 0, nx, acc);
    end
    chk("sec_saturated", 64'(o_sec_cnt), 64'(SAT_EXP));
    d = $urandom;
    c = ref_encode(d);
    d[$urandom_range(0, 31)] ^= 1'b1;
    drive(1, d, c, 1, 1, 0, nx, acc);
    chk("sec_cleared", 64'(o_sec_cnt), 64'd0);
    chk("sticky_cleared", 64'(o_err_sticky), 64'd0);

    // Randomized traffic with 0..2 bit errors, raw check bits and clears.
    for (int k = 0; k < 400; k++) begin
      v    = ($urandom_range(0, 3) != 0);
      rdy  = ($urandom_range(0, 3) != 0);
      clr  = ($urandom_range(0, 31) == 0);
      d    = $urandom;
      c    = ref_encode(d);
      mode = $urandom_range(0, 9);
      cwv  = {c, d};
      b1   = $urandom_range(0, 38);
      b2   = (b1 + 1 + $urandom_range(0, 37)) % 39;
      if (mode >= 4) cwv[b1] = ~cwv[b1];
      if (mode >= 7 && mode <= 8) cwv[b2] = ~cwv[b2];
      if (mode == 9) cwv[38:32] = 7'($urandom);
      drive(v, cwv[31:0], cwv[38:32], rdy, clr, 0, nx, acc);
    end

    // Reset while a word sits in the output stage.
    drive(0, 32'h0, 7'h0, 1, 0, 0, nx, acc);
    d = $urandom;
    drive(1, d, ref_encode(d) ^ 7'h01, 0, 0, 0, nx, acc);
    #2;
    chk("pre_reset_valid", 64'(bus.o_valid), 64'd1);
    i_rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 64'(bus.o_valid), 64'd0);
    chk("async_rst_dat", 64'(bus.o_dat), 64'd0);
    chk("async_rst_flags", 64'({bus.o_sec, bus.o_ded, bus.o_syndrome}), 64'd0);
    chk("async_rst_counts", 64'({o_sec_cnt, o_ded_cnt, o_err_sticky}), 64'd0);
    sb.delete();
    m_sec = 0; m_ded = 0; m_sticky = 1'b0; acc_seen = 1'b0;
    @(posedge i_clk);
    #3 i_rst_n = 1'b1;
    d = $urandom;
    drive(1, d, ref_encode(d), 1, 0, 0, nx, acc);
    chk("post_reset_accept", 64'(acc), 64'd1);
    chk("post_reset_valid", 64'(bus.o_valid), 64'd1);
    chk("post_reset_dat", 64'(bus.o_dat), 64'(d));

    for (int k = 0; k < 3; k++) drive(0, 32'h0, 7'h0, 1, 0, 0, nx, acc);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/edc_checker.md
EDC_CHECKER -- requirements
Module: edc_checker

Interface
REQ-001 Parameter WB_DWIDTH, default 32: data width; only 32 is supported, and any other value is a compile-time error.
REQ-002 Parameter WB_SWIDTH, default 4: byte-select width; carried for bus consistency and unused internally.
REQ-003 Parameter CNT_WIDTH, default 16: width of each error counter.
REQ-004 i_clk  in  1  sole clock; all state changes on its rising edge.
REQ-005 i_rst_n  in  1  asynchronous, active-low reset.
REQ-006 i_valid  in  1  input word and check bits present.
REQ-007 o_ready  out  1  checker accepts the input word this cycle.
REQ-008 i_dat  in  WB_DWIDTH  received data word.
REQ-009 i_chk  in  7  received check bits, as produced by the EDC generator.
REQ-010 o_valid  out  1  output word valid.
REQ-011 i_ready  in  1  downstream accepts the output word.
REQ-012 o_dat  out  WB_DWIDTH  corrected data.
REQ-013 o_sec  out  1  output word had a single error and was corrected.
REQ-014 o_ded  out  1  output word had an uncorrectable error.
REQ-015 o_syndrome  out  7  syndrome of the output word: {overall parity, s[5:0]}.
REQ-016 i_clr  in  1  synchronous clear of the counters and the sticky flag.
REQ-017 o_sec_cnt, o_ded_cnt  out  CNT_WIDTH each  error counters.
REQ-018 o_err_sticky  out  1  set by any SEC or DED event and held until i_clr.

Function
REQ-019 The code SHALL be Hamming SECDED (39,32).
- Data bit i maps to the i-th non-power-of-two position, ascending from 3 (positions 3, 5, 6, 7, 9, ..., 38).
- c[k] (k = 0..5) is the XOR of the data bits whose position has bit k set.
- c[6] makes the parity of all 39 bits even.
REQ-020 s[5:0] SHALL equal the recomputed c[5:0] XOR i_chk[5:0]; p SHALL equal the XOR of all 39 received bits.
REQ-021 Classification SHALL be:
- p=0, s=0: clean.
- p=1, s=0: error in c[6]; SEC, data unchanged.
- p=1, s a power of two: check-bit error; SEC, data unchanged.
- p=1, s a data position: flip that data bit; SEC.
- p=1, s>38: DED.
- p=0, s!=0: DED.
REQ-022 On DED, o_dat SHALL carry i_dat unmodified.
REQ-023 There SHALL be one registered output stage, with latency exactly 1 cycle from acceptance to o_valid.
REQ-024 o_ready SHALL equal (!o_valid || i_ready), combinationally.
REQ-025 A word SHALL be accepted when i_valid && o_ready; the output registers SHALL load only on acceptance.
REQ-026 o_valid SHALL set on acceptance, clear when o_valid && i_ready && !i_valid, and stay high on simultaneous drain-and-accept (full throughput).
REQ-027 While o_valid && !i_ready, o_dat, o_sec, o_ded and o_syndrome SHALL hold stable.
REQ-028 Each counter SHALL increment by one per accepted SEC (o_sec_cnt) or DED (o_ded_cnt) word and SHALL saturate at all-ones.
REQ-029 i_clr SHALL have priority over a same-cycle increment: the counter becomes 0 and that event is not counted; o_err_sticky clears.
REQ-030 o_err_sticky SHALL set on the cycle after an accepted SEC or DED word unless i_clr is asserted in the acceptance cycle.

Reset
REQ-031 While i_rst_n=0, all registers SHALL clear immediately: o_valid, o_dat, o_sec, o_ded, o_syndrome, counters and o_err_sticky all 0.
REQ-032 A word held in the output stage when reset asserts SHALL be discarded.
REQ-033 The first acceptance SHALL be possible in the first clock cycle after reset deasserts.

Configuration
REQ-034 When EDC_CHECKER_COUNTERS_EN is defined, the counters and o_err_sticky SHALL be implemented as above.
REQ-035 When EDC_CHECKER_COUNTERS_EN is undefined, o_sec_cnt, o_ded_cnt and o_err_sticky SHALL be tied to 0, i_clr SHALL be ignored, and the datapath behaviour SHALL be identical.

Structure
REQ-036 Package edc_pkg SHALL hold:
- the check-bit width (7);
- the data-to-position mapping table;
- the check-bit mask constants;
- the error-class enum {CLEAN, SEC, DED}.
The encoder SHALL share the same package.
REQ-037 The combinational syndrome, decode and correct logic SHALL be the sub-module edc_syndrome; edc_checker holds the handshake register and counters.

Verification
REQ-038 i_dat=0x00000000, i_chk=0x00 -> next cycle: o_dat=0x00000000, o_sec=0, o_ded=0, o_syndrome=0x00.
REQ-039 i_dat=0x00000000, i_chk=0x43 (bit 0 flipped from 0x00000001) -> o_dat=0x00000001, o_sec=1, o_syndrome=0x43, o_sec_cnt=1.
REQ-040 i_dat=0x00000003, i_chk=0x00 -> o_ded=1, o_dat=0x00000003, o_syndrome=0x06, o_ded_cnt=1, o_err_sticky=1.
REQ-041 Stream 4 words with i_ready held low for 3 cycles -> o_ready=0 and o_dat stable while stalled; all 4 words emerge in order, with no loss or duplicate.
REQ-042 CNT_WIDTH=4, 17 SEC words, then i_clr asserted together with one more SEC -> o_sec_cnt saturates at 0xF and then reads 0.
REQ-043 i_rst_n pulsed low mid-stream while o_valid=1 -> o_valid=0 and all counters 0 immediately; the next accepted word appears 1 cycle later.
